// File: rtl/moore_sched_pkg.sv
// moore_sched_pkg
// Shared types and constants for the moore_stream_sched scheduler and its
// detector core.
//   sched_state_t : scheduler FSM states
//   det_state_t   : Moore detector states; S4 is the "pattern seen" state
//   PATTERN       : serial bit pattern searched for, first bit at [3]
package moore_sched_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DRAIN, DONE} sched_state_t;
  typedef enum logic [2:0] {S0, S1, S2, S3, S4} det_state_t;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/moore_det_core.sv
// moore_det_core
// Registered Moore detector for PATTERN with overlap. The hit output is a
// pure decode of the state register, so a match becomes visible the cycle
// after its last bit is fed.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  synchronous active-high reset (state -> S0)
//   clr    in  synchronous clear to S0, wins over en
//   en     in  advance the FSM with bit_in this cycle
//   bit_in in  serial input bit
//   hit    out 1 while the state is S4
module moore_det_core
  import moore_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic hit
);

  det_state_t r_state;
  det_state_t w_nxt;

  // Fallback states keep the longest suffix that is still a pattern prefix.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S0: w_nxt = (bit_in == PATTERN[3]) ? S1 : S0;
      S1: w_nxt = (bit_in == PATTERN[2]) ? S2 : S1;
      S2: w_nxt = (bit_in == PATTERN[1]) ? S3 : S0;
      S3: w_nxt = (bit_in == PATTERN[0]) ? S4 : S2;
      S4: w_nxt = bit_in ? S1 : S2;
      default: w_nxt = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) r_state <= S0;
    else if (en)    r_state <= w_nxt;
  end

  assign hit = (r_state == S4);

endmodule

// File: rtl/moore_stream_sched.sv
// moore_stream_sched
// Round-robin scheduler that shares one Moore "1011" detector between NREQ
// requesters. A granted word is serialised MSB-first into the detector and
// the number of overlapping hits is returned with a one-cycle done pulse.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   req     in   [NREQ]   request per channel
//   data    in   [NREQ*W] flat words, channel i at data[i*W +: W]
//   lock    in   [NREQ]   only when SCHED_LOCK_EN is defined: keep the
//                         channel that just finished if it still requests
//   gnt     out  [NREQ]   one-hot grant pulse (word captured that cycle)
//   busy    out           grant cycle through done cycle
//   done    out           one-cycle result strobe
//   done_id out  [IDW]    channel of the last finished word
//   hit_cnt out  [CW]     hits in the last finished word
// Optional feature macro: SCHED_LOCK_EN.
module moore_stream_sched
  import moore_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  localparam int IDW = $clog2(NREQ),
  localparam int CW  = $clog2(W + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*W-1:0]    data,
`ifdef SCHED_LOCK_EN
  input  logic [NREQ-1:0]      lock,
`endif
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 done,
  output logic [IDW-1:0]       done_id,
  output logic [CW-1:0]        hit_cnt
);

  sched_state_t   r_state, w_nxt;
  logic [IDW-1:0] r_ptr;      // last granted channel
  logic [IDW-1:0] r_win;      // channel being served / about to be granted
  logic [W-1:0]   r_word;
  logic [CW-1:0]  r_bitcnt;
  logic [CW-1:0]  r_cnt;
  logic [IDW-1:0] r_done_id;
  logic [CW-1:0]  r_hit;

  logic [IDW-1:0] w_win, w_hi;
  logic           w_hi_found;
  logic           w_det_clr, w_det_en, w_det_hit;

  // Round-robin pick: lowest requester above r_ptr, else lowest overall.
  // The loop runs downward so the last assignment is the lowest index.
  always_comb begin
    w_hi       = '0;
    w_hi_found = 1'b0;
    w_win      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_win = IDW'(i);
        if (i > int'(r_ptr)) begin
          w_hi       = IDW'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    if (w_hi_found) w_win = w_hi;
  end

  // FSM next state and Moore outputs
  always_comb begin
    w_nxt     = r_state;
    gnt       = '0;
    busy      = 1'b1;
    done      = 1'b0;
    w_det_clr = 1'b0;
    w_det_en  = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (|req) w_nxt = LOAD;
      end
      LOAD: begin
        gnt[r_win] = 1'b1;
        w_det_clr  = 1'b1;
        w_nxt      = SHIFT;
      end
      SHIFT: begin
        w_det_en = 1'b1;
        if (r_bitcnt == CW'(W - 1)) w_nxt = DRAIN;
      end
      DRAIN: w_nxt = DONE;
      DONE: begin
        done  = 1'b1;
        w_nxt = IDLE;
`ifdef SCHED_LOCK_EN
        if (req[r_done_id] && lock[r_done_id]) w_nxt = LOAD;
`endif
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= IDW'(NREQ - 1);
      r_win     <= '0;
      r_word    <= '0;
      r_bitcnt  <= '0;
      r_cnt     <= '0;
      r_done_id <= '0;
      r_hit     <= '0;
    end else begin
      case (r_state)
        IDLE: r_win <= w_win;
        LOAD: begin
          r_word   <= data[int'(r_win)*W +: W];
          r_bitcnt <= '0;
          r_cnt    <= '0;
          r_ptr    <= r_win;
        end
        SHIFT: begin
          r_word   <= r_word << 1;
          r_bitcnt <= r_bitcnt + 1'b1;
          // The first SHIFT cycle sees the cleared S0, so counting here
          // covers exactly the hits produced by this word.
          if (w_det_hit) r_cnt <= r_cnt + 1'b1;
        end
        DRAIN: begin
          // The last bit's match only shows up now; fold it in directly so
          // the result is valid in the DONE cycle itself.
          r_done_id <= r_win;
          r_hit     <= r_cnt + {{(CW-1){1'b0}}, w_det_hit};
        end
        DONE: r_win <= r_done_id;  // used only when the lock path re-grants
        default: ;
      endcase
    end
  end

  moore_det_core u_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_det_clr),
    .en     (w_det_en),
    .bit_in (r_word[W-1]),
    .hit    (w_det_hit)
  );

  assign done_id = r_done_id;
  assign hit_cnt = r_hit;

endmodule
